late_wb_arbiter: RTL and testbench

Merges the variable-latency result producers of the back end (divider, dcache load return, CSR read) onto one shared late register-file write port. Each source has a one-entry holding slot. Full slots are drained round-robin into a registered write port that sits beside the two fixed-latency ALU write ports of the writeback stage. A pending-destination mask lets issue logic hold dependent instructions.

---
 rtl/late_wb_pkg.sv | 13 +
 rtl/late_wb_arbiter_rr.sv | 27 ++
 rtl/late_wb_arbiter.sv | 76 +++++++
 tb/tb_late_wb_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/late_wb_pkg.sv
// late_wb_pkg: source indices and request type shared by the late writeback arbiter.
package late_wb_pkg;
  localparam int NSRC = 3;
  localparam int SRC_DIV = 0;
  localparam int SRC_DCACHE = 1;
  localparam int SRC_CSR = 2;
  localparam int DEF_RD_W = 5;
  localparam int DEF_DATA_W = 32;
  typedef struct packed {
    logic [DEF_RD_W-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/late_wb_arbiter_rr.sv
// rr_arbiter: round-robin pick among requests, searching upward from i_ptr.
module rr_arbiter #(
  parameter int N = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx
);
  int c;
  // Scan from farthest to nearest so the first requester after i_ptr overwrites last.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    c = 0;
    for (int k = N - 1; k >= 0; k--) begin
      c = (int'(i_ptr) + k) % N;
      if (i_en && i_req[c]) begin
        o_gnt = '0;
        o_gnt[c] = 1'b1;
        o_idx = PW'(c);
      end
    end
  end
endmodule

// File: rtl/late_wb_arbiter.sv
// late_wb_arbiter: per-source holding slots drained round-robin onto one registered RF write port.
module late_wb_arbiter import late_wb_pkg::*; #(
  parameter int NSRC = late_wb_pkg::NSRC,
  parameter int DATA_W = 32,
  parameter int RD_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [NSRC-1:0]        src_valid,
  output logic [NSRC-1:0]        src_ready,
  input  logic [NSRC*RD_W-1:0]   src_rd,
  input  logic [NSRC*DATA_W-1:0] src_data,
  output logic                   wb_we,
  output logic [RD_W-1:0]        wb_rd,
  output logic [DATA_W-1:0]      wb_data,
  output logic [31:0]            pend_mask,
  output logic                   busy
);
  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;
  logic [NSRC-1:0]   r_full;
  logic [RD_W-1:0]   r_rd [NSRC];
  logic [DATA_W-1:0] r_data [NSRC];
  logic [PW-1:0]     r_ptr;
  logic [NSRC-1:0]   w_gnt;
  logic [NSRC-1:0]   w_hs;
  logic [PW-1:0]     w_win;
  logic              w_any;

  rr_arbiter #(.N(NSRC), .PW(PW)) u_rr (
    .i_req(r_full),
    .i_ptr(r_ptr),
    .i_en(~flush),
    .o_gnt(w_gnt),
    .o_idx(w_win)
  );

  assign w_any = |w_gnt;
  assign src_ready = {NSRC{~reset & ~flush}} & (~r_full | w_gnt);
  assign w_hs = src_valid & src_ready;
  assign busy = (|r_full) | wb_we;

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < NSRC; i++)
      if (r_full[i]) pend_mask[r_rd[i]] = 1'b1;
  end

  // A capture on a slot being granted this cycle wins over the clear; rd==0 results are dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (reset || flush) r_full[i] <= 1'b0;
      else if (w_hs[i] && src_rd[i*RD_W +: RD_W] != '0) begin
        r_full[i] <= 1'b1;
        r_rd[i] <= src_rd[i*RD_W +: RD_W];
        r_data[i] <= src_data[i*DATA_W +: DATA_W];
      end else if (w_gnt[i]) r_full[i] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
      wb_we <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
    end else begin
      wb_we <= w_any;
      wb_rd <= w_any ? r_rd[w_win] : '0;
      if (w_any) begin
        wb_data <= r_data[w_win];
        r_ptr <= (w_win == PW'(NSRC - 1)) ? '0 : w_win + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_late_wb_arbiter.sv
// tb_late_wb_arbiter: directed scenario tests for the late writeback arbiter.
module tb_late_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [2:0]  src_valid = '0;
  logic [2:0]  src_ready;
  logic [14:0] src_rd = '0;
  logic [95:0] src_data = '0;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] pend_mask;
  logic        busy;
  int checks = 0;
  int errors = 0;

  late_wb_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready), .src_rd(src_rd), .src_data(src_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .pend_mask(pend_mask), .busy(busy)
  );

  always #5 clk = ~clk;

  // Producers may not offer an rd that another source's full slot still holds.
  always @(posedge clk)
    if (!reset)
      for (int i = 0; i < 3; i++)
        if (src_valid[i] && src_ready[i] && src_rd[i*5 +: 5] != 5'd0)
          for (int j = 0; j < 3; j++)
            if (j != i && dut.r_full[j] && dut.r_rd[j] == src_rd[i*5 +: 5])
              $error("ordering contract violated by source %0d", i);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] v, input logic [4:0] r0, r1, r2,
                       input logic [31:0] d0, d1, d2);
    src_valid = v;
    src_rd = {r2, r1, r0};
    src_data = {d2, d1, d0};
  endtask

  task automatic idle();
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(3'b111, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd3);
    step();
    step();
    mid();
    checks++; if (src_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b exp 000", src_ready); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b exp 0", wb_we); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d exp 0", wb_rd); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h exp 0", wb_data); end
    checks++; if (pend_mask !== 32'd0) begin errors++; $display("FAIL reset_pend: got %h exp 0", pend_mask); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    step();
    reset = 1'b0;
    idle();
    mid();
  endtask

  task automatic test_single();
    step();
    drive(3'b001, 5'd5, 5'd0, 5'd0, 32'h1234, 32'd0, 32'd0);
    mid();
    checks++; if (src_ready[0] !== 1'b1) begin errors++; $display("FAIL single_ready: got %b exp 1", src_ready[0]); end
    step();
    idle();
    mid();
    checks++; if (pend_mask !== 32'h20) begin errors++; $display("FAIL single_pend: got %h exp 20", pend_mask); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL single_early_we: got %b exp 0", wb_we); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy1: got %b exp 1", busy); end
    step();
    mid();
    checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL single_we: got %b exp 1", wb_we); end
    checks++; if (wb_rd !== 5'd5) begin errors++; $display("FAIL single_rd: got %0d exp 5", wb_rd); end
    checks++; if (wb_data !== 32'h1234) begin errors++; $display("FAIL single_data: got %h exp 1234", wb_data); end
    checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL single_pend_fall: got %h exp 0", pend_mask); end
    step();
    mid();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy0: got %b exp 0", busy); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL single_rd_idle: got %0d exp 0", wb_rd); end
    checks++; if (wb_data !== 32'h1234) begin errors++; $display("FAIL single_data_hold: got %h exp 1234", wb_data); end
  endtask

  task automatic test_contention();
    logic [4:0]  exp_rd [3];
    logic [31:0] exp_d [3];
    logic [31:0] exp_p [3];
    exp_rd = '{5'd1, 5'd2, 5'd3};
    exp_d = '{32'hA, 32'hB, 32'hC};
    exp_p = '{32'hC, 32'h8, 32'h0};
    step();
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
    drive(3'b111, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'hC);
    mid();
    checks++; if (src_ready !== 3'b111) begin errors++; $display("FAIL cont_ready: got %b exp 111", src_ready); end
    step();
    idle();
    mid();
    checks++; if (pend_mask !== 32'hE) begin errors++; $display("FAIL cont_pend: got %h exp e", pend_mask); end
    for (int k = 0; k < 3; k++) begin
      step();
      mid();
      checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL cont_we%0d: got %b exp 1", k, wb_we); end
      checks++; if (wb_rd !== exp_rd[k]) begin errors++; $display("FAIL cont_rd%0d: got %0d exp %0d", k, wb_rd, exp_rd[k]); end
      checks++; if (wb_data !== exp_d[k]) begin errors++; $display("FAIL cont_data%0d: got %h exp %h", k, wb_data, exp_d[k]); end
      checks++; if (pend_mask !== exp_p[k]) begin errors++; $display("FAIL cont_pend%0d: got %h exp %h", k, pend_mask, exp_p[k]); end
    end
    step();
    mid();
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL cont_we_end: got %b exp 0", wb_we); end
    checks++; if (dut.r_ptr !== 2'd0) begin errors++; $display("FAIL cont_ptr: got %0d exp 0", dut.r_ptr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [4];
    d = '{32'h100, 32'h201, 32'h302, 32'h403};
    for (int k = 0; k < 6; k++) begin
      step();
      if (k < 4) drive(3'b010, 5'd0, 5'd7, 5'd0, 32'd0, d[k], 32'd0);
      else idle();
      mid();
      if (k < 4) begin
        checks++; if (src_ready[1] !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b exp 1", k, src_ready[1]); end
      end
      if (k == 1) begin
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL b2b_latency: got %b exp 0", wb_we); end
      end
      if (k >= 2) begin
        checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL b2b_we%0d: got %b exp 1", k, wb_we); end
        checks++; if (wb_rd !== 5'd7) begin errors++; $display("FAIL b2b_rd%0d: got %0d exp 7", k, wb_rd); end
        checks++; if (wb_data !== d[k-2]) begin errors++; $display("FAIL b2b_data%0d: got %h exp %h", k, wb_data, d[k-2]); end
      end
    end
  endtask

  task automatic test_flush();
    step();
    drive(3'b101, 5'd4, 5'd0, 5'd9, 32'h44, 32'd0, 32'h99);
    mid();
    step();
    drive(3'b100, 5'd0, 5'd0, 5'd12, 32'd0, 32'd0, 32'hCC);
    flush = 1'b1;
    mid();
    checks++; if (src_ready !== 3'b000) begin errors++; $display("FAIL flush_ready: got %b exp 000", src_ready); end
    checks++; if (pend_mask !== 32'h210) begin errors++; $display("FAIL flush_pend_before: got %h exp 210", pend_mask); end
    step();
    flush = 1'b0;
    idle();
    mid();
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL flush_we: got %b exp 0", wb_we); end
    checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL flush_pend: got %h exp 0", pend_mask); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b exp 0", busy); end
    checks++; if (dut.r_ptr !== 2'd2) begin errors++; $display("FAIL flush_ptr: got %0d exp 2", dut.r_ptr); end
    step();
    mid();
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL flush_no_csr_write: got %b exp 0", wb_we); end
  endtask

  task automatic test_rd0_drop();
    step();
    drive(3'b100, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'hDEAD);
    mid();
    checks++; if (src_ready[2] !== 1'b1) begin errors++; $display("FAIL rd0_ready: got %b exp 1", src_ready[2]); end
    step();
    idle();
    mid();
    checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL rd0_pend: got %h exp 0", pend_mask); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd0_busy: got %b exp 0", busy); end
    step();
    mid();
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL rd0_we: got %b exp 0", wb_we); end
  endtask

  task automatic test_reset_mid();
    step();
    drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
    step();
    idle();
    reset = 1'b1;
    mid();
    checks++; if (pend_mask !== 32'hE) begin errors++; $display("FAIL rmid_pend_full: got %h exp e", pend_mask); end
    checks++; if (src_ready !== 3'b000) begin errors++; $display("FAIL rmid_ready: got %b exp 000", src_ready); end
    step();
    reset = 1'b0;
    drive(3'b001, 5'd6, 5'd0, 5'd0, 32'h55, 32'd0, 32'd0);
    mid();
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL rmid_we: got %b exp 0", wb_we); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL rmid_rd: got %0d exp 0", wb_rd); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL rmid_data: got %h exp 0", wb_data); end
    checks++; if (dut.r_ptr !== 2'd0) begin errors++; $display("FAIL rmid_ptr: got %0d exp 0", dut.r_ptr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b exp 0", busy); end
    step();
    idle();
    mid();
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL rmid_post_early: got %b exp 0", wb_we); end
    checks++; if (pend_mask !== 32'h40) begin errors++; $display("FAIL rmid_post_pend: got %h exp 40", pend_mask); end
    step();
    mid();
    checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL rmid_post_we: got %b exp 1", wb_we); end
    checks++; if (wb_rd !== 5'd6) begin errors++; $display("FAIL rmid_post_rd: got %0d exp 6", wb_rd); end
    checks++; if (wb_data !== 32'h55) begin errors++; $display("FAIL rmid_post_data: got %h exp 55", wb_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_flush();
    test_rd0_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
